// File: rtl/uart_reg_writer.sv
// uart_reg_writer: round-robin write arbiter feeding the serial register decoder.
// Each accepted write becomes [bank-select], low-nibble, high-nibble bytes sent as
// 8N1 frames at BAUD_DIV clocks per bit, followed by GAP_BITS idle bit periods.
// Build macro BANK_CACHE_EN: omit the bank-select byte when the bank is already selected.
`timescale 1ns/1ps
module uart_reg_writer #(
  parameter int NUM_REQ  = 4,
  parameter int BAUD_DIV = 5,
  parameter int GAP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_bank,
  input  logic [2*NUM_REQ-1:0] req_reg,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 tx,
  output logic [1:0]           cur_bank
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEL, S_LO, S_HI} state_t;
  typedef enum logic [2:0] {PH_LOAD, PH_START, PH_DATA, PH_STOP, PH_GAP} phase_t;

  state_t               r_state;
  phase_t               r_phase;
  logic [BW-1:0]        r_baud;
  logic [2:0]           r_bit;
  logic [1:0]           r_gap;
  logic [PW-1:0]        r_ptr;
  logic [NUM_REQ-1:0]   r_grant;
  logic                 r_busy;
  logic                 r_tx;
  logic [1:0]           r_cur_bank;
  logic [1:0]           r_bank;
  logic [1:0]           r_reg;
  logic [7:0]           r_data;
`ifdef BANK_CACHE_EN
  logic                 r_bank_valid;
`endif

  logic                 w_found;
  logic [PW-1:0]        w_idx;
  logic [1:0]           w_bank;
  logic [1:0]           w_reg;
  logic [7:0]           w_data;
  logic                 w_need_sel;
  logic [7:0]           w_byte;
  logic                 w_next_bit;
  logic                 w_baud_end;
  logic                 w_byte_done;

  // Requester index 'off' positions after 'base', wrapping modulo NUM_REQ.
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  // Round-robin pick: first requester after the last granted one, plus its payload.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_bank  = '0;
    w_reg   = '0;
    w_data  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!w_found && req[rr_index(r_ptr, i)]) begin
        w_found = 1'b1;
        w_idx   = rr_index(r_ptr, i);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_idx == PW'(k)) begin
        w_bank = req_bank[2*k +: 2];
        w_reg  = req_reg[2*k +: 2];
        w_data = req_data[8*k +: 8];
      end
    end
  end

`ifdef BANK_CACHE_EN
  assign w_need_sel = !r_bank_valid || (w_bank != r_cur_bank);
`else
  assign w_need_sel = 1'b1;
`endif

  // Protocol byte for the byte state currently on the wire.
  always_comb begin
    case (r_state)
      S_SEL:   w_byte = {1'b1, 5'b0, r_bank};
      S_LO:    w_byte = {1'b0, r_reg, 1'b0, r_data[3:0]};
      S_HI:    w_byte = {1'b0, r_reg, 1'b1, r_data[7:4]};
      default: w_byte = 8'hFF;
    endcase
  end

  assign w_next_bit  = w_byte[r_bit + 3'd1];
  assign w_baud_end  = (r_baud == BW'(BAUD_DIV - 1));
  assign w_byte_done = w_baud_end &&
                       (((r_phase == PH_STOP) && (GAP_BITS == 0)) ||
                        ((r_phase == PH_GAP) && (r_gap == 2'(GAP_BITS - 1))));

  // Capture the granted requester's payload at the moment of arbitration.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_found) begin
      r_bank <= w_bank;
      r_reg  <= w_reg;
      r_data <= w_data;
    end
  end

  // Transaction FSM: arbitration, byte sequencing and bit-level framing; tx is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_phase      <= PH_LOAD;
      r_baud       <= '0;
      r_bit        <= '0;
      r_gap        <= '0;
      r_ptr        <= PW'(NUM_REQ - 1);
      r_grant      <= '0;
      r_busy       <= 1'b0;
      r_tx         <= 1'b1;
      r_cur_bank   <= '0;
`ifdef BANK_CACHE_EN
      r_bank_valid <= 1'b0;
`endif
    end else begin
      r_grant <= '0;
      if (r_state == S_IDLE) begin
        r_tx <= 1'b1;
        if (w_found) begin
          r_grant <= NUM_REQ'(1) << w_idx;
          r_busy  <= 1'b1;
          r_ptr   <= w_idx;
          r_phase <= PH_LOAD;
          r_baud  <= '0;
          r_state <= w_need_sel ? S_SEL : S_LO;
        end
      end else if (w_byte_done) begin
        // Byte finished: chain straight into the next start bit, or end the transaction.
        r_baud <= '0;
        case (r_state)
          S_SEL: begin
            r_cur_bank   <= r_bank;
`ifdef BANK_CACHE_EN
            r_bank_valid <= 1'b1;
`endif
            r_state      <= S_LO;
            r_phase      <= PH_START;
            r_tx         <= 1'b0;
          end
          S_LO: begin
            r_state <= S_HI;
            r_phase <= PH_START;
            r_tx    <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_phase <= PH_LOAD;
            r_busy  <= 1'b0;
            r_tx    <= 1'b1;
          end
        endcase
      end else if (r_phase == PH_LOAD) begin
        // Grant cycle: the start bit goes out from the next cycle.
        r_tx    <= 1'b0;
        r_phase <= PH_START;
        r_baud  <= '0;
      end else if (!w_baud_end) begin
        r_baud <= r_baud + BW'(1);
      end else begin
        r_baud <= '0;
        case (r_phase)
          PH_START: begin
            r_phase <= PH_DATA;
            r_bit   <= '0;
            r_tx    <= w_byte[0];
          end
          PH_DATA: begin
            if (r_bit == 3'd7) begin
              r_phase <= PH_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= w_next_bit;
            end
          end
          PH_STOP: begin
            r_phase <= PH_GAP;
            r_gap   <= '0;
            r_tx    <= 1'b1;
          end
          default: begin
            r_gap <= r_gap + 2'd1;
            r_tx  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign grant    = r_grant;
  assign busy     = r_busy;
  assign tx       = r_tx;
  assign cur_bank = r_cur_bank;

endmodule

// File: tb/tb_uart_reg_writer.sv
// Directed testbench for uart_reg_writer: decodes tx frames and models the register decoder.
`timescale 1ns/1ps
module tb_uart_reg_writer;

  localparam int NR = 4;
  localparam int BD = 5;
  localparam int GB = 1;
  localparam int BYTE_CYC = (10 + GB) * BD;
`ifdef BANK_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [2*NR-1:0] req_bank = '0;
  logic [2*NR-1:0] req_reg = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            tx;
  logic [1:0]      cur_bank;

  uart_reg_writer #(.NUM_REQ(NR), .BAUD_DIV(BD), .GAP_BITS(GB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_bank(req_bank), .req_reg(req_reg),
    .req_data(req_data), .grant(grant), .busy(busy), .tx(tx), .cur_bank(cur_bank)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame receiver plus register-decoder model, sampling mid-bit on the falling edge.
  logic [7:0] rx_q[$];
  int         frame_err = 0;
  int         gnt_cnt = 0;
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] mreg [0:15];
  int         ev_cnt [0:3] = '{0, 0, 0, 0};
  logic [1:0] m_bank = '0;
  logic [3:0] m_lo = '0;

  always @(negedge clk) begin
    if (grant != '0) gnt_cnt++;
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == BD/2 + 9*BD) begin
        if (tx !== 1'b1) frame_err++;
        rx_q.push_back(rx_sh);
        if (rx_sh[7]) m_bank = rx_sh[1:0];
        else if (!rx_sh[4]) m_lo = rx_sh[3:0];
        else begin
          mreg[{m_bank, rx_sh[6:5]}] = {rx_sh[3:0], m_lo};
          ev_cnt[m_bank]++;
        end
        rx_act = 1'b0;
      end else if (rx_cnt > BD/2 && (rx_cnt - BD/2) % BD == 0) begin
        rx_sh[(rx_cnt - BD/2)/BD - 1] = tx;
      end
    end
    if (rx_act && rx_cnt == BD/2 && tx !== 1'b0) frame_err++;
  end

  task automatic set_req(input int i, input logic [1:0] b, input logic [1:0] r,
                         input logic [7:0] d, input logic v);
    req_bank[2*i +: 2] = b;
    req_reg[2*i +: 2]  = r;
    req_data[8*i +: 8] = d;
    req[i]             = v;
  endtask

  task automatic wait_grant(output logic [NR-1:0] g, output int gc);
    g  = '0;
    gc = -1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (grant != '0) begin
        g  = grant;
        gc = cyc;
        return;
      end
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic xfer(input string tag, input int i, input logic [1:0] b, input logic [1:0] r,
                      input logic [7:0] d, input logic [NR-1:0] exp_g, output int nbusy);
    logic [NR-1:0] g;
    int gc;
    set_req(i, b, r, d, 1'b1);
    wait_grant(g, gc);
    check({tag, "_grant"}, 32'(g), 32'(exp_g));
    req[i] = 1'b0;
    @(negedge clk);
    check({tag, "_start"}, 32'(tx), 32'd0);
    wait_idle(nbusy);
  endtask

  task automatic check_bytes(input string tag, input int base, input logic [7:0] e[$]);
    check({tag, "_nbytes"}, 32'(rx_q.size() - base), 32'(e.size()));
    foreach (e[k]) check($sformatf("%s_byte%0d", tag, k), 32'(rx_q[base + k]), 32'(e[k]));
  endtask

  initial begin
    logic [NR-1:0] g;
    int gc, n, base, g0, lo_start, tx_low;
    logic [7:0] e[$];

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_cur_bank", 32'(cur_bank), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Scenario 1: first write, bank select always sent
    base = rx_q.size();
    set_req(0, 2'd2, 2'd3, 8'hAF, 1'b1);
    wait_grant(g, gc);
    check("s1_grant", 32'(g), 32'h1);
    check("s1_busy_at_grant", 32'(busy), 32'd1);
    check("s1_tx_at_grant", 32'(tx), 32'd1);
    req[0] = 1'b0;
    @(negedge clk);
    check("s1_start", 32'(tx), 32'd0);
    check("s1_grant_pulse", 32'(grant), 32'd0);
    wait_idle(n);
    check("s1_busy_len", 32'(n), 32'(3*BYTE_CYC));
    e = '{8'h82, 8'h6F, 8'h7A};
    check_bytes("s1", base, e);
    check("s1_cur_bank", 32'(cur_bank), 32'd2);
    // Scenario 5: decoder model fed by the same frames
    check("s5_reg11", 32'(mreg[11]), 32'hAF);
    check("s5_event_bank2", 32'(ev_cnt[2]), 32'd1);

    // Scenario 2: same-bank write
    base = rx_q.size();
    xfer("s2", 1, 2'd2, 2'd0, 8'h12, 4'b0010, n);
    check("s2_busy_len", 32'(n), CACHE ? 32'(2*BYTE_CYC) : 32'(3*BYTE_CYC));
    if (CACHE) e = '{8'h02, 8'h11};
    else       e = '{8'h82, 8'h02, 8'h11};
    check_bytes("s2", base, e);

    // Scenario 3: round-robin ordering
    xfer("s3a", 0, 2'd1, 2'd1, 8'h55, 4'b0001, n);
    set_req(0, 2'd0, 2'd0, 8'h01, 1'b1);
    set_req(2, 2'd3, 2'd2, 8'h02, 1'b1);
    wait_grant(g, gc);
    check("s3_first", 32'(g), 32'b0100);
    req[2] = 1'b0;
    wait_grant(g, gc);
    check("s3_second", 32'(g), 32'b0001);
    req[0] = 1'b0;
    repeat (40) @(negedge clk);
    set_req(3, 2'd2, 2'd1, 8'h03, 1'b1);
    wait_grant(g, gc);
    check("s3_third", 32'(g), 32'b1000);
    req[3] = 1'b0;
    @(negedge clk);
    wait_idle(n);
    check("s3_idle", 32'(busy), 32'd0);

    // Scenario 4: reset during data bit 4 of the LO byte
    set_req(1, 2'd2, 2'd1, 8'h10, 1'b1);
    wait_grant(g, gc);
    check("s4_grant", 32'(g), 32'b0010);
    req[1] = 1'b0;
    lo_start = gc + 1 + (CACHE ? 0 : BYTE_CYC);
    while (cyc < lo_start + 26) @(negedge clk);
    check("s4_lo_bit4", 32'(tx), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("s4_rst_tx", 32'(tx), 32'd1);
    check("s4_rst_busy", 32'(busy), 32'd0);
    check("s4_rst_grant", 32'(grant), 32'd0);
    check("s4_rst_cur_bank", 32'(cur_bank), 32'd0);
    g0 = gnt_cnt;
    tx_low = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low++;
    end
    check("s4_no_regrant", 32'(gnt_cnt - g0), 32'd0);
    check("s4_tx_idle", 32'(tx_low), 32'd0);
    base = rx_q.size();
    xfer("s4b", 1, 2'd2, 2'd1, 8'h10, 4'b0010, n);
    check("s4b_busy_len", 32'(n), 32'(3*BYTE_CYC));
    e = '{8'h82, 8'h20, 8'h31};
    check_bytes("s4b", base, e);

    // Scenario 6: short request pulse while busy is ignored
    base = rx_q.size();
    g0 = gnt_cnt;
    set_req(1, 2'd2, 2'd2, 8'h3C, 1'b1);
    wait_grant(g, gc);
    check("s6_grant", 32'(g), 32'b0010);
    req[1] = 1'b0;
    repeat (20) @(negedge clk);
    set_req(2, 2'd1, 2'd3, 8'hEE, 1'b1);
    @(negedge clk);
    req[2] = 1'b0;
    wait_idle(n);
    repeat (80) @(negedge clk);
    check("s6_grant_count", 32'(gnt_cnt - g0), 32'd1);
    if (CACHE) e = '{8'h4C, 8'h53};
    else       e = '{8'h82, 8'h4C, 8'h53};
    check_bytes("s6", base, e);
    check("s6_busy", 32'(busy), 32'd0);

    check("frame_errors", 32'(frame_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
